// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Match sequencer for the Pong datapath. Holds the IDLE/SERVE/PLAY/POINT/OVER
//   state machine, both player scores and the serve direction. It gates ball and
//   paddle physics with per-frame strobes and parks the ball at centre between
//   points.
//
// Ports
//   iVGA_CLK    pixel clock (only clock)
//   reset       synchronous active-high reset
//   frame_tick  one-cycle pulse per frame (vertical-sync start)
//   sw          run switch: 0 = run, 1 = hold/clear
//   miss_left   ball passed player 1's paddle (sampled only in PLAY)
//   miss_right  ball passed player 2's paddle (sampled only in PLAY)
//   phys_step   one-cycle ball-update strobe
//   paddle_en   paddle movement allowed
//   ball_reset  hold ball at centre
//   serve_dir   0 = toward player 1, 1 = toward player 2
//   p1score     player 1 score
//   p2score     player 2 score
//   game_over   match finished
//   winner      0 = player 1, 1 = player 2 (valid while game_over)
//   state       IDLE=0 SERVE=1 PLAY=2 POINT=3 OVER=4
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int SCORE_W      = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 30,
  parameter int MOVE_DIV     = 1
) (
  input  logic               iVGA_CLK,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               sw,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               phys_step,
  output logic               paddle_en,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] p1score,
  output logic [SCORE_W-1:0] p2score,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  // Zero-length waits are stretched to one frame so the FSM always sees a tick.
  localparam int SERVE_EFF = (SERVE_FRAMES < 1) ? 1 : SERVE_FRAMES;
  localparam int POINT_EFF = (POINT_FRAMES < 1) ? 1 : POINT_FRAMES;
  localparam int CNT_MAX   = (SERVE_EFF > POINT_EFF) ? SERVE_EFF : POINT_EFF;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DIV_W     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LD = CNT_W'(SERVE_EFF);
  localparam logic [CNT_W-1:0]   POINT_LD = CNT_W'(POINT_EFF);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(MOVE_DIV - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  state_t             st;
  logic [CNT_W-1:0]   frame_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;

  // Saturating score increment: a score never passes WIN_SCORE and never wraps.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s >= WIN_VAL) ? s : s + 1'b1;
  endfunction

  assign p1_next = score_inc(p1score);
  assign p2_next = score_inc(p2score);
  assign state   = st;

  // paddle_en / ball_reset are written alongside each state change so they are
  // registered and always agree with the state they belong to.
  always_ff @(posedge iVGA_CLK) begin
    phys_step <= 1'b0;
    if (reset) begin
      st         <= IDLE;
      p1score    <= '0;
      p2score    <= '0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      game_over  <= 1'b0;
      paddle_en  <= 1'b0;
      ball_reset <= 1'b1;
      frame_cnt  <= '0;
      div_cnt    <= '0;
    end else if (sw) begin
      st         <= IDLE;
      p1score    <= '0;
      p2score    <= '0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      game_over  <= 1'b0;
      paddle_en  <= 1'b0;
      ball_reset <= 1'b1;
    end else begin
      unique case (st)
        IDLE: begin
          st         <= SERVE;
          frame_cnt  <= SERVE_LD;
          paddle_en  <= 1'b1;
          ball_reset <= 1'b1;
        end
        SERVE: begin
          if (frame_tick) begin
            frame_cnt <= frame_cnt - 1'b1;
            if (frame_cnt == CNT_ONE) begin
              st         <= PLAY;
              div_cnt    <= '0;
              ball_reset <= 1'b0;
            end
          end
        end
        PLAY: begin
          if (miss_left || miss_right) begin
            // Any miss ends the rally; a coincident frame_tick yields no step.
            paddle_en  <= 1'b0;
            ball_reset <= 1'b1;
            st         <= POINT;
            frame_cnt  <= POINT_LD;
            if (miss_left && !miss_right) begin
              p2score   <= p2_next;
              serve_dir <= 1'b0;
              if (p2_next == WIN_VAL) begin
                st        <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b1;
              end
            end else if (miss_right && !miss_left) begin
              p1score   <= p1_next;
              serve_dir <= 1'b1;
              if (p1_next == WIN_VAL) begin
                st        <= OVER;
                game_over <= 1'b1;
                winner    <= 1'b0;
              end
            end
          end else if (frame_tick) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt   <= '0;
              phys_step <= 1'b1;
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end
        end
        POINT: begin
          if (frame_tick) begin
            frame_cnt <= frame_cnt - 1'b1;
            if (frame_cnt == CNT_ONE) begin
              st        <= SERVE;
              frame_cnt <= SERVE_LD;
              paddle_en <= 1'b1;
            end
          end
        end
        OVER: begin
          // Frozen until sw or reset.
        end
        default: begin
          st         <= IDLE;
          paddle_en  <= 1'b0;
          ball_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-sequencing controller for the Pong datapath. It owns the match state machine, the player scores and the serve direction. It gates the ball/paddle physics with per-frame step strobes and resets the ball between points. It sits between the video sync generator (which supplies frame_tick) and the ball/paddle update logic (which reports misses and consumes phys_step, paddle_en and ball_reset).

Parameters:
WIN_SCORE, 11, score that ends the match; must be <= 2^SCORE_W-1
SCORE_W, 4, width of each score counter
SERVE_FRAMES, 60, frames the ball is held at centre before play; a value of 0 is treated as 1
POINT_FRAMES, 30, frames of pause after a point is scored; a value of 0 is treated as 1
MOVE_DIV, 1, phys_step fires on every MOVE_DIV-th frame_tick during PLAY; must be >= 1

Ports:
iVGA_CLK  input  1  pixel clock; the only clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per frame, asserted at vertical-sync start
sw  input  1  run switch: 0 = game running, 1 = hold/clear
miss_left  input  1  ball passed player 1's paddle (level, sampled only in PLAY)
miss_right  input  1  ball passed player 2's paddle (level, sampled only in PLAY)
phys_step  output  1  one-cycle ball-update strobe
paddle_en  output  1  paddle movement allowed (level)
ball_reset  output  1  hold the ball at centre (level)
serve_dir  output  1  initial ball direction: 0 = toward player 1 (left), 1 = toward player 2 (right)
p1score  output  SCORE_W  player 1 score
p2score  output  SCORE_W  player 2 score
game_over  output  1  match finished
winner  output  1  0 = player 1, 1 = player 2; valid only while game_over=1
state  output  3  IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4

Behaviour:
- All logic is clocked on the rising edge of iVGA_CLK. All outputs are registered.
- Reset values:
  - state=IDLE; scores=0; serve_dir=0; winner=0; game_over=0; phys_step=0; paddle_en=0; ball_reset=1.
  - Frame counter and divider counter = 0.
- Priority: reset > sw==1 > FSM transitions. sw==1 in any state puts the block in IDLE on the next cycle, clears scores, serve_dir, winner and game_over, and forces ball_reset=1.
- IDLE:
  - ball_reset=1, paddle_en=0.
  - When sw==0, load frame counter = max(SERVE_FRAMES,1) and go to SERVE.
- SERVE:
  - ball_reset=1, paddle_en=1.
  - Each frame_tick decrements the counter.
  - The tick that takes the counter from 1 to 0 moves the FSM to PLAY on the next cycle and clears the divider.
- PLAY:
  - ball_reset=0, paddle_en=1.
  - Divider counts frame_ticks from 0 to MOVE_DIV-1, then wraps.
  - phys_step=1 for exactly the cycle after each frame_tick on which the divider equals MOVE_DIV-1 (1-cycle latency). With MOVE_DIV=1, every tick produces a step.
- Miss handling (evaluated only in PLAY; ignored in all other states):
  - miss_left only: p2score+1, serve_dir<=0.
  - miss_right only: p1score+1, serve_dir<=1.
  - Both in the same cycle: no score change, serve_dir unchanged, point replayed.
  - If the new score equals WIN_SCORE: go to OVER, winner = the scorer, game_over=1.
  - Otherwise: go to POINT with counter = max(POINT_FRAMES,1).
  - A miss that coincides with a frame_tick takes priority; no phys_step is issued for that tick.
- POINT:
  - ball_reset=1, paddle_en=0.
  - Counter decrements on frame_tick. When it reaches 0, load SERVE_FRAMES and go to SERVE.
- OVER:
  - ball_reset=1, paddle_en=0, scores frozen, game_over=1.
  - Leave only via sw==1 (to IDLE) or reset.
- Scores never exceed WIN_SCORE and never wrap.
- phys_step is 0 outside PLAY and is never asserted on two consecutive cycles.
- Reset asserted mid-frame or mid-point: every register takes its reset value on the next edge; a pending count is discarded.

Test Plan:
- Params SERVE_FRAMES=3, MOVE_DIV=2; reset, then sw=0 -> state goes 0→1; after exactly 3 frame_ticks state=2 and ball_reset=0; the next 4 ticks produce exactly 2 phys_step pulses, each 1 cycle wide, 1 cycle after the 2nd and 4th ticks.
- In PLAY, pulse miss_left -> p2score 0→1, serve_dir=0, state=3; after POINT_FRAMES ticks state=1. Pulse miss_right in PLAY -> p1score=1, serve_dir=1.
- miss_left and miss_right asserted in the same cycle -> scores unchanged, serve_dir unchanged, state=3.
- WIN_SCORE=3; player 2 scores three points -> state=4, game_over=1, winner=1; further misses and ticks leave p2score=3; then sw=1 -> state=0, scores=0, game_over=0.
- miss_left asserted during SERVE and POINT -> no score change; frame_tick with SERVE counter=1 and sw=1 in the same cycle -> state=IDLE, not PLAY.
- reset asserted during PLAY with p1score=5 -> next cycle state=0, scores=0, ball_reset=1, phys_step=0.
